// File: rtl/rf_write_arbiter_if.sv
// Purpose: requester, clear-control and register-file write-port bundle for rf_write_arbiter.
// Latency: pure wiring; grants are combinational, write-port fields are registered by the arbiter.
// Backpressure: a requester holds req/addr/data until its gnt; the write port itself never stalls.
interface rf_write_arbiter_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4
);
    logic              clr_go;
    logic              a_req;
    logic [ADDR_W-1:0] a_addr;
    logic [DATA_W-1:0] a_data;
    logic              a_gnt;
    logic              b_req;
    logic [ADDR_W-1:0] b_addr;
    logic [DATA_W-1:0] b_data;
    logic              b_gnt;
    logic              rf_wr_en;
    logic [ADDR_W-1:0] rf_wr_addr;
    logic [DATA_W-1:0] rf_wr_data;
    logic              clr_busy;
    logic              clr_done;

    // Arbiter side: consumes requests, produces grants and the write port.
    modport slave (
        input  clr_go, a_req, a_addr, a_data, b_req, b_addr, b_data,
        output a_gnt, b_gnt, rf_wr_en, rf_wr_addr, rf_wr_data, clr_busy, clr_done
    );

    // Requester / controller side.
    modport master (
        output clr_go, a_req, a_addr, a_data, b_req, b_addr, b_data,
        input  a_gnt, b_gnt, rf_wr_en, rf_wr_addr, rf_wr_data, clr_busy, clr_done
    );
endinterface

// File: rtl/rf_write_arbiter.sv
// Purpose: round-robin share of the register-file write port between A and B, plus a zero-fill clear sweep.
// Latency: grant in the request cycle, write enable on the port one cycle later; sweep takes DEPTH cycles.
// Backpressure: losers and requests during a sweep simply see no gnt and keep holding req.
module rf_write_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    rf_write_arbiter_if.slave  bus
);
    localparam int                DEPTH    = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] CNT_LAST = ADDR_W'(DEPTH - 1);

    typedef enum logic {
        ARB   = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t            state_q;
    logic [ADDR_W-1:0] cnt_q;
    logic [ADDR_W-1:0] cnt_d;
    logic              last_b_q;
    logic              wr_en_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [DATA_W-1:0] wr_data_q;
    logic              done_q;
    logic              arb_ok;
    logic              a_win;
    logic              b_win;

    // Grants only exist in ARB, outside reset, and lose to a clear request.
    // On a tie, last_b_q picks whoever was not served most recently.
    assign arb_ok = !rst && (state_q == ARB) && !bus.clr_go;
    assign a_win  = arb_ok && bus.a_req && (!bus.b_req || last_b_q);
    assign b_win  = arb_ok && bus.b_req && (!bus.a_req || !last_b_q);
    assign cnt_d  = cnt_q + 1'b1;

    assign bus.a_gnt      = a_win;
    assign bus.b_gnt      = b_win;
    assign bus.rf_wr_en   = wr_en_q;
    assign bus.rf_wr_addr = wr_addr_q;
    assign bus.rf_wr_data = wr_data_q;
    assign bus.clr_busy   = (state_q == CLEAR);
    assign bus.clr_done   = done_q;

    // Arbitration / sweep FSM with registered write-port outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ARB;
            cnt_q     <= '0;
            last_b_q  <= 1'b1;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ARB: begin
                    if (bus.clr_go) begin
                        state_q <= CLEAR;
                        cnt_q   <= '0;
                        wr_en_q <= 1'b0;
                    end else if (a_win) begin
                        wr_en_q   <= 1'b1;
                        wr_addr_q <= bus.a_addr;
                        wr_data_q <= bus.a_data;
                        last_b_q  <= 1'b0;
                    end else if (b_win) begin
                        wr_en_q   <= 1'b1;
                        wr_addr_q <= bus.b_addr;
                        wr_data_q <= bus.b_data;
                        last_b_q  <= 1'b1;
                    end else begin
                        // Address and data hold; only the enable drops.
                        wr_en_q <= 1'b0;
                    end
                end
                CLEAR: begin
                    // clr_go is deliberately ignored here so a sweep is never restarted.
                    wr_en_q   <= 1'b1;
                    wr_addr_q <= cnt_q;
                    wr_data_q <= '0;
                    cnt_q     <= cnt_d;
                    if (cnt_q == CNT_LAST) begin
                        state_q <= ARB;
                        done_q  <= 1'b1;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_rf_write_arbiter.sv
// Purpose: self-checking bench for rf_write_arbiter with a behavioural register file and reference model.
// Latency: inputs driven 1ns after the rising edge, grants sampled 2ns after, registered outputs 1ns after.
// Backpressure: bench requesters hold req/addr/data until granted.
module tb_rf_write_arbiter;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    rf_write_arbiter_if #(.DATA_W(32), .ADDR_W(4)) bus ();

    rf_write_arbiter #(.DATA_W(32), .ADDR_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural 16 x 32 register file sitting behind the write port.
    logic [31:0] rf [16];
    always @(posedge clk) begin
        if (bus.rf_wr_en === 1'b1) rf[bus.rf_wr_addr] <= bus.rf_wr_data;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.clr_go = 1'b0;
        bus.a_req  = 1'b0;
        bus.a_addr = '0;
        bus.a_data = '0;
        bus.b_req  = 1'b0;
        bus.b_addr = '0;
        bus.b_data = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic preload(input logic [31:0] base, input bit incr);
        for (int i = 0; i < 16; i++) begin
            bus.a_req  = 1'b1;
            bus.a_addr = 4'(i);
            bus.a_data = incr ? base + 32'(i) : base;
            tick();
        end
        bus.a_req = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst        = 1'b1;
        bus.clr_go = 1'b1;
        bus.a_req  = 1'b1;
        bus.a_addr = '1;
        bus.a_data = '1;
        bus.b_req  = 1'b1;
        bus.b_addr = '1;
        bus.b_data = '1;
        #1;
        checks++;
        if (bus.a_gnt !== 1'b0 || bus.b_gnt !== 1'b0) begin
            errors++;
            $display("FAIL reset_gnt_initial got a=%b b=%b exp 0 0", bus.a_gnt, bus.b_gnt);
        end
        for (int c = 0; c < 2; c++) begin
            tick();
            checks++;
            if (bus.a_gnt !== 1'b0 || bus.b_gnt !== 1'b0) begin
                errors++;
                $display("FAIL reset_gnt cyc%0d got a=%b b=%b exp 0 0", c, bus.a_gnt, bus.b_gnt);
            end
            checks++;
            if (bus.rf_wr_en !== 1'b0 || bus.rf_wr_addr !== 4'h0 || bus.rf_wr_data !== 32'h0 ||
                bus.clr_busy !== 1'b0 || bus.clr_done !== 1'b0) begin
                errors++;
                $display("FAIL reset_outputs cyc%0d got en=%b addr=%h data=%h busy=%b done=%b exp all 0",
                         c, bus.rf_wr_en, bus.rf_wr_addr, bus.rf_wr_data, bus.clr_busy, bus.clr_done);
            end
        end
        idle_inputs();
        rst = 1'b0;
    endtask

    task automatic test_single();
        logic [31:0] d;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            d = 32'h11 * 32'(i + 1);
            bus.a_req  = 1'b1;
            bus.a_addr = 4'(3 + i);
            bus.a_data = d;
            #1;
            checks++;
            if (bus.a_gnt !== 1'b1 || bus.b_gnt !== 1'b0) begin
                errors++;
                $display("FAIL single_gnt %0d got a=%b b=%b exp 1 0", i, bus.a_gnt, bus.b_gnt);
            end
            tick();
            checks++;
            if (bus.rf_wr_en !== 1'b1 || bus.rf_wr_addr !== 4'(3 + i) || bus.rf_wr_data !== d) begin
                errors++;
                $display("FAIL single_port %0d got en=%b addr=%h data=%h exp 1 %h %h",
                         i, bus.rf_wr_en, bus.rf_wr_addr, bus.rf_wr_data, 4'(3 + i), d);
            end
        end
        bus.a_req = 1'b0;
        tick();
        checks++;
        if (bus.rf_wr_en !== 1'b0 || rf[4] !== 32'h22) begin
            errors++;
            $display("FAIL single_read got en=%b rf4=%h exp 0 00000022", bus.rf_wr_en, rf[4]);
        end
    endtask

    task automatic test_contention();
        logic [3:0]  a_addrs [4] = '{4'd7, 4'd1, 4'd2, 4'd3};
        logic [3:0]  b_addrs [4] = '{4'd7, 4'd9, 4'd10, 4'd11};
        int          ai;
        int          bi;
        int          writes;
        bit          exp_a;
        logic [3:0]  ea;
        logic [31:0] ed;
        do_reset();
        ai     = 0;
        bi     = 0;
        writes = 0;
        for (int k = 0; k < 4; k++) begin
            bus.a_req  = 1'b1;
            bus.a_addr = a_addrs[ai];
            bus.a_data = 32'hA000 + 32'(ai);
            bus.b_req  = 1'b1;
            bus.b_addr = b_addrs[bi];
            bus.b_data = 32'hB000 + 32'(bi);
            #1;
            exp_a = (k % 2 == 0);
            checks++;
            if (bus.a_gnt !== exp_a || bus.b_gnt !== !exp_a) begin
                errors++;
                $display("FAIL contention_gnt %0d got a=%b b=%b exp %b %b", k, bus.a_gnt, bus.b_gnt, exp_a, !exp_a);
            end
            ea = exp_a ? a_addrs[ai] : b_addrs[bi];
            ed = exp_a ? 32'hA000 + 32'(ai) : 32'hB000 + 32'(bi);
            if (exp_a) ai++;
            else bi++;
            tick();
            if (bus.rf_wr_en === 1'b1) writes++;
            checks++;
            if (bus.rf_wr_en !== 1'b1 || bus.rf_wr_addr !== ea || bus.rf_wr_data !== ed) begin
                errors++;
                $display("FAIL contention_port %0d got en=%b addr=%h data=%h exp 1 %h %h",
                         k, bus.rf_wr_en, bus.rf_wr_addr, bus.rf_wr_data, ea, ed);
            end
        end
        idle_inputs();
        tick();
        if (bus.rf_wr_en === 1'b1) writes++;
        checks++;
        if (writes != 4) begin
            errors++;
            $display("FAIL contention_count got %0d exp 4", writes);
        end
    endtask

    task automatic test_clear();
        int busy_cnt;
        int done_cnt;
        int bad;
        do_reset();
        preload(32'hFFFF_FFFF, 1'b0);
        checks++;
        if (rf[9] !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL clear_preload got %h exp ffffffff", rf[9]);
        end
        bus.clr_go = 1'b1;
        #1;
        tick();
        bus.clr_go = 1'b0;
        busy_cnt = 0;
        done_cnt = 0;
        for (int j = 0; j <= 16; j++) begin
            if (bus.clr_busy === 1'b1) busy_cnt++;
            if (bus.clr_done === 1'b1) done_cnt++;
            checks++;
            if (bus.clr_busy !== (j < 16) || bus.clr_done !== (j == 16) || bus.rf_wr_en !== (j >= 1)) begin
                errors++;
                $display("FAIL clear_ctrl j%0d got busy=%b done=%b en=%b exp %b %b %b",
                         j, bus.clr_busy, bus.clr_done, bus.rf_wr_en, j < 16, j == 16, j >= 1);
            end
            if (j >= 1) begin
                checks++;
                if (bus.rf_wr_addr !== 4'(j - 1) || bus.rf_wr_data !== 32'h0) begin
                    errors++;
                    $display("FAIL clear_addr j%0d got addr=%h data=%h exp %h 0",
                             j, bus.rf_wr_addr, bus.rf_wr_data, 4'(j - 1));
                end
            end
            tick();
        end
        checks++;
        if (bus.clr_busy !== 1'b0 || bus.clr_done !== 1'b0 || bus.rf_wr_en !== 1'b0 ||
            busy_cnt != 16 || done_cnt != 1) begin
            errors++;
            $display("FAIL clear_after got busy=%b done=%b en=%b busy_cycles=%0d done_pulses=%0d exp 0 0 0 16 1",
                     bus.clr_busy, bus.clr_done, bus.rf_wr_en, busy_cnt, done_cnt);
        end
        bad = 0;
        for (int i = 0; i < 16; i++) if (rf[i] !== 32'h0) bad++;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL clear_contents got %0d nonzero entries exp 0", bad);
        end
    endtask

    task automatic test_clear_vs_req();
        bus.clr_go = 1'b1;
        bus.a_req  = 1'b1;
        bus.a_addr = 4'd15;
        bus.a_data = 32'hCAFE_F00D;
        #1;
        checks++;
        if (bus.a_gnt !== 1'b0) begin
            errors++;
            $display("FAIL cvr_go_cycle got a_gnt=%b exp 0", bus.a_gnt);
        end
        tick();
        bus.clr_go = 1'b0;
        for (int j = 0; j <= 16; j++) begin
            #1;
            checks++;
            if (bus.a_gnt !== (j == 16) || bus.clr_done !== (j == 16)) begin
                errors++;
                $display("FAIL cvr_wait j%0d got a_gnt=%b done=%b exp %b %b", j, bus.a_gnt, bus.clr_done, j == 16, j == 16);
            end
            if (j == 16) begin
                checks++;
                if (bus.rf_wr_en !== 1'b1 || bus.rf_wr_addr !== 4'd15 || bus.rf_wr_data !== 32'h0) begin
                    errors++;
                    $display("FAIL cvr_last_clear got en=%b addr=%h data=%h exp 1 f 0",
                             bus.rf_wr_en, bus.rf_wr_addr, bus.rf_wr_data);
                end
            end
            tick();
        end
        bus.a_req = 1'b0;
        checks++;
        if (bus.rf_wr_en !== 1'b1 || bus.rf_wr_addr !== 4'd15 || bus.rf_wr_data !== 32'hCAFE_F00D) begin
            errors++;
            $display("FAIL cvr_a_write got en=%b addr=%h data=%h exp 1 f cafef00d",
                     bus.rf_wr_en, bus.rf_wr_addr, bus.rf_wr_data);
        end
        tick();
        checks++;
        if (rf[15] !== 32'hCAFE_F00D) begin
            errors++;
            $display("FAIL cvr_read got %h exp cafef00d", rf[15]);
        end
    endtask

    task automatic test_reset_mid_sweep();
        int done_cnt;
        int bad;
        do_reset();
        preload(32'h100, 1'b1);
        done_cnt   = 0;
        bus.clr_go = 1'b1;
        tick();
        bus.clr_go = 1'b0;
        for (int k = 0; k < 7; k++) begin
            if (bus.clr_done === 1'b1) done_cnt++;
            tick();
        end
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (bus.clr_done === 1'b1) done_cnt++;
            tick();
        end
        checks++;
        if (done_cnt != 0 || bus.clr_busy !== 1'b0 || bus.rf_wr_en !== 1'b0) begin
            errors++;
            $display("FAIL midsweep_ctrl got done_pulses=%0d busy=%b en=%b exp 0 0 0", done_cnt, bus.clr_busy, bus.rf_wr_en);
        end
        bad = 0;
        for (int i = 0; i < 7; i++) if (rf[i] !== 32'h0) bad++;
        for (int i = 8; i < 16; i++) if (rf[i] !== 32'h100 + 32'(i)) bad++;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL midsweep_contents got %0d wrong entries exp 0", bad);
        end
    endtask

    task automatic test_random();
        // Reference model: a clear is sixteen zero writes in address order with no grants;
        // otherwise a lone requester wins, and a tie goes to whoever was not served last.
        logic [31:0] mem_exp [16];
        int          clear_left;
        int          clear_idx;
        bit          last_was_b;
        bit          a_pend, b_pend;
        bit          go, ea, eb, exp_busy;
        bit          nx_en, nx_done;
        logic [3:0]  nx_addr;
        logic [31:0] nx_data;
        int          bad;
        do_reset();
        for (int i = 0; i < 16; i++) mem_exp[i] = 32'h0;
        clear_left = 0;
        clear_idx  = 0;
        last_was_b = 1'b1;
        a_pend     = 1'b0;
        b_pend     = 1'b0;
        for (int c = 0; c < 430; c++) begin
            if (c < 400) begin
                go = (c == 0) || ($urandom_range(0, 49) == 0);
                if (!a_pend && $urandom_range(0, 2) != 0) begin
                    a_pend     = 1'b1;
                    bus.a_addr = 4'($urandom_range(0, 15));
                    bus.a_data = $urandom;
                end
                if (!b_pend && $urandom_range(0, 2) != 0) begin
                    b_pend     = 1'b1;
                    bus.b_addr = 4'($urandom_range(0, 15));
                    bus.b_data = $urandom;
                end
            end else begin
                go = 1'b0;
            end
            bus.clr_go = go;
            bus.a_req  = a_pend;
            bus.b_req  = b_pend;
            #1;
            ea       = 1'b0;
            eb       = 1'b0;
            nx_en    = 1'b0;
            nx_done  = 1'b0;
            nx_addr  = '0;
            nx_data  = '0;
            exp_busy = (clear_left > 0);
            if (clear_left > 0) begin
                nx_en   = 1'b1;
                nx_addr = 4'(clear_idx);
                clear_idx++;
                clear_left--;
                nx_done = (clear_left == 0);
            end else if (go) begin
                clear_left = 16;
                clear_idx  = 0;
            end else begin
                if (a_pend && b_pend) begin
                    ea = last_was_b;
                    eb = !last_was_b;
                end else begin
                    ea = a_pend;
                    eb = b_pend;
                end
                if (ea) begin
                    nx_en      = 1'b1;
                    nx_addr    = bus.a_addr;
                    nx_data    = bus.a_data;
                    last_was_b = 1'b0;
                end
                if (eb) begin
                    nx_en      = 1'b1;
                    nx_addr    = bus.b_addr;
                    nx_data    = bus.b_data;
                    last_was_b = 1'b1;
                end
            end
            checks++;
            if (bus.a_gnt !== ea || bus.b_gnt !== eb || bus.clr_busy !== exp_busy) begin
                errors++;
                $display("FAIL random_gnt c%0d got a=%b b=%b busy=%b exp %b %b %b",
                         c, bus.a_gnt, bus.b_gnt, bus.clr_busy, ea, eb, exp_busy);
            end
            tick();
            if (ea) a_pend = 1'b0;
            if (eb) b_pend = 1'b0;
            if (nx_en) mem_exp[nx_addr] = nx_data;
            checks++;
            if (bus.rf_wr_en !== nx_en || bus.clr_done !== nx_done ||
                (nx_en && (bus.rf_wr_addr !== nx_addr || bus.rf_wr_data !== nx_data))) begin
                errors++;
                $display("FAIL random_port c%0d got en=%b addr=%h data=%h done=%b exp %b %h %h %b",
                         c, bus.rf_wr_en, bus.rf_wr_addr, bus.rf_wr_data, bus.clr_done,
                         nx_en, nx_addr, nx_data, nx_done);
            end
        end
        idle_inputs();
        tick();
        bad = 0;
        for (int i = 0; i < 16; i++) if (rf[i] !== mem_exp[i]) bad++;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL random_contents got %0d wrong entries exp 0", bad);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        for (int i = 0; i < 16; i++) rf[i] = 32'h0;
        idle_inputs();
        test_reset();
        test_single();
        test_contention();
        test_clear();
        test_clear_vs_req();
        test_reset_mid_sweep();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
